// File: rtl/template_ram_writer_pkg.sv
// Shared definitions for template_ram_writer.
//   tpl_state_e : writer state (IDLE / LOAD / FINISH)
//   TPL_CSUM_W  : width of the optional running checksum
package tpl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } tpl_state_e;

  localparam int unsigned TPL_CSUM_W = 16;

endpackage

// File: rtl/template_ram_writer.sv
// template_ram_writer: streams a start-triggered block of words into a
// single-port RAM at consecutive addresses 0..len_m1.
//
// Parameters
//   c_ADDR_WIDTH : RAM address width (1..20)
//   c_DATA_WIDTH : RAM word width (8..1152)
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start, len_m1    : begin a load of len_m1+1 words (accepted in IDLE only)
//   abort            : terminate the load in progress, no done pulse
//   s_valid, s_data  : input stream; s_ready high only while loading
//   ram_addr, ram_wr_data, ram_wr_en : RAM write port, one cycle after accept
//   busy             : load in progress (LOAD or FINISH)
//   done             : one-cycle pulse coinciding with the final RAM write
// Optional build macro
//   TPL_WR_CHECKSUM_EN : adds output checksum, the modulo-2^16 sum of the low
//                        16 bits of every word written in the current load.
module template_ram_writer
  import tpl_pkg::*;
#(
  parameter int unsigned c_ADDR_WIDTH = 10,
  parameter int unsigned c_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [c_ADDR_WIDTH-1:0] len_m1,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic [c_DATA_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic [c_ADDR_WIDTH-1:0] ram_addr,
  output logic [c_DATA_WIDTH-1:0] ram_wr_data,
  output logic                    ram_wr_en,
  output logic                    busy,
  output logic                    done
`ifdef TPL_WR_CHECKSUM_EN
  ,
  output logic [TPL_CSUM_W-1:0]   checksum
`endif
);

  tpl_state_e state_q, state_d;

  logic [c_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [c_ADDR_WIDTH-1:0] len_q, len_d;
  logic [c_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [c_DATA_WIDTH-1:0] data_q, data_d;
  logic                    wr_en_q, wr_en_d;

  logic accept;
  logic last_beat;

  assign accept    = (state_q == LOAD) && s_valid;
  assign last_beat = accept && (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = accept;

    if (accept) begin
      addr_d = cnt_q;
      data_d = s_data;
      // The final beat leaves LOAD, so holding the counter there keeps it
      // from wrapping when len_m1 is the maximum address.
      if (!last_beat) begin
        cnt_d = cnt_q + c_ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          len_d   = len_m1;
        end
      end
      LOAD: begin
        // abort wins over a simultaneous final beat: the write still lands
        // via wr_en_d above, but FINISH (and thus done) is skipped.
        if (abort) begin
          state_d = IDLE;
        end else if (last_beat) begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign ram_addr    = addr_q;
  assign ram_wr_data = data_q;
  assign ram_wr_en   = wr_en_q;

`ifdef TPL_WR_CHECKSUM_EN
  localparam int unsigned LOW_W =
    (c_DATA_WIDTH < TPL_CSUM_W) ? c_DATA_WIDTH : TPL_CSUM_W;

  logic [TPL_CSUM_W-1:0] csum_q, csum_d;
  logic [TPL_CSUM_W-1:0] beat_low;

  always_comb begin
    beat_low = '0;
    beat_low[LOW_W-1:0] = s_data[LOW_W-1:0];
  end

  // Summing at accept time (not at the registered write) makes the total
  // complete in the FINISH cycle, aligned with done.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + beat_low;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_template_ram_writer.sv
`timescale 1ns/1ps
module tb_template_ram_writer;
  import tpl_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] len_m1 = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic          busy;
  logic          done;
`ifdef TPL_WR_CHECKSUM_EN
  logic [TPL_CSUM_W-1:0] checksum;
`endif

  template_ram_writer #(
    .c_ADDR_WIDTH(AW),
    .c_DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len_m1      (len_m1),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en),
    .busy        (busy),
    .done        (done)
`ifdef TPL_WR_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   c;
    int unsigned   a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         obs_w[$];
  wr_t         exp_w[$];
  int unsigned obs_done[$];
  int unsigned exp_done[$];
  int unsigned obs_fall[$];
  int unsigned exp_fall[$];

  int unsigned cyc = 0;
  logic        prev_busy = 1'b0;
  int          total = 0;
  int          bad = 0;

  // Reference model: loading / finishing flags, beat index, length, sum.
  bit          m_loading = 0;
  bit          m_finishing = 0;
  int unsigned m_k = 0;
  int unsigned m_len = 0;
  logic [15:0] m_sum = '0;

  // Monitor: cyc = index of the posedge just taken; sample 2ns later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (ram_wr_en === 1'b1) obs_w.push_back('{cyc, 32'(ram_addr), ram_wr_data});
    if (done === 1'b1) obs_done.push_back(cyc);
    if (prev_busy === 1'b1 && busy === 1'b0) obs_fall.push_back(cyc);
    prev_busy = busy;
  end

  function automatic string wr_diff();
    if (obs_w.size() != exp_w.size())
      return $sformatf("got %0d writes want %0d", obs_w.size(), exp_w.size());
    foreach (obs_w[i]) begin
      if (obs_w[i].c != exp_w[i].c || obs_w[i].a != exp_w[i].a || obs_w[i].d !== exp_w[i].d)
        return $sformatf("write %0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                         i, obs_w[i].c, obs_w[i].a, obs_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
    end
    return "";
  endfunction

  function automatic string list_diff(input int unsigned got[$], input int unsigned want[$]);
    if (got.size() != want.size())
      return $sformatf("got %0d events want %0d", got.size(), want.size());
    foreach (got[i]) begin
      if (got[i] != want[i])
        return $sformatf("event %0d got cyc=%0d want cyc=%0d", i, got[i], want[i]);
    end
    return "";
  endfunction

  task automatic clear_q();
    obs_w.delete(); exp_w.delete();
    obs_done.delete(); exp_done.delete();
    obs_fall.delete(); exp_fall.delete();
  endtask

  // Drive one cycle of inputs (sampled at the next posedge) and predict its
  // effect: the k-th accepted beat of a load lands at address k one cycle
  // later; the (len+1)-th beat also brings done, and busy falls after it.
  task automatic step(input bit st, input int unsigned ln, input bit ab,
                      input bit v, input logic [DW-1:0] d);
    bit last;
    last    = 0;
    rst     = 1'b0;
    start   = st;
    len_m1  = AW'(ln);
    abort   = ab;
    s_valid = v;
    s_data  = d;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (m_loading) begin
      if (v) begin
        exp_w.push_back('{cyc + 1, m_k, d});
        m_sum = m_sum + d[15:0];
        last  = (m_k == m_len);
        m_k++;
      end
      if (ab) begin
        m_loading = 0;
        exp_fall.push_back(cyc + 1);
      end else if (last) begin
        m_loading   = 0;
        m_finishing = 1;
        exp_done.push_back(cyc + 1);
        exp_fall.push_back(cyc + 2);
      end
    end else if (st) begin
      m_loading = 1;
      m_k       = 0;
      m_len     = ln;
      m_sum     = '0;
    end
    @(negedge clk);
  endtask

  task automatic reset_step(input bit v, input logic [DW-1:0] d);
    rst     = 1'b1;
    start   = 1'($urandom_range(0, 1));
    len_m1  = AW'($urandom);
    abort   = 1'b0;
    s_valid = v;
    s_data  = d;
    if (m_loading) exp_fall.push_back(cyc + 1);
    m_loading   = 0;
    m_finishing = 0;
    m_k         = 0;
    m_sum       = '0;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, $urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) reset_step(1'b1, $urandom);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", ram_wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_addr got %h want 0", ram_addr); end
    total++; if (ram_wr_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", ram_wr_data); end
`ifdef TPL_WR_CHECKSUM_EN
    total++; if (checksum !== '0) begin bad++; $display("FAIL reset_checksum got %h want 0", checksum); end
`endif
    clear_q();
  endtask

  task automatic test_basic();
    string s;
    clear_q();
    step(1, 3, 0, 0, $urandom);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hA0 + i);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom);
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL basic_writes %s", s); end
    s = list_diff(obs_done, exp_done); total++; if (s != "") begin bad++; $display("FAIL basic_done %s", s); end
    s = list_diff(obs_fall, exp_fall); total++; if (s != "") begin bad++; $display("FAIL basic_busy_fall %s", s); end
    total++;
    if (obs_w.size() != 4 || obs_w[3].a != 3 || obs_w[3].d !== 32'hA3 || obs_done.size() != 1 || obs_done[0] != obs_w[3].c) begin
      bad++; $display("FAIL basic_last_write got %0d writes/%0d dones want 4 writes, last addr 3 data a3 with done", obs_w.size(), obs_done.size());
    end
  endtask

  task automatic test_gaps();
    string s;
    clear_q();
    step(1, 2, 0, 0, $urandom);
    for (int unsigned i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, $urandom);
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL gaps_writes %s", s); end
    s = list_diff(obs_done, exp_done); total++; if (s != "") begin bad++; $display("FAIL gaps_done %s", s); end
    total++; if (obs_w.size() != 3) begin bad++; $display("FAIL gaps_count got %0d want 3", obs_w.size()); end
  endtask

  task automatic test_full_fill();
    string s;
    clear_q();
    step(1, 15, 0, 0, $urandom);
    for (int unsigned i = 0; i < 20; i++) step(0, 0, 0, 1, $urandom);
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL fill_writes %s", s); end
    s = list_diff(obs_done, exp_done); total++; if (s != "") begin bad++; $display("FAIL fill_done %s", s); end
    total++; if (obs_w.size() != 16) begin bad++; $display("FAIL fill_count got %0d want 16", obs_w.size()); end
  endtask

  task automatic test_abort_start();
    string s;
    clear_q();
    step(1, 7, 0, 0, $urandom);
    step(0, 0, 0, 1, $urandom);
    step(1, 0, 0, 1, $urandom);     // start while loading: must not restart
    step(0, 0, 1, 0, $urandom);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_s_ready got %b want 0", s_ready); end
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL abort_writes %s", s); end
    total++; if (obs_done.size() != 0) begin bad++; $display("FAIL abort_no_done got %0d pulses want 0", obs_done.size()); end
    s = list_diff(obs_fall, exp_fall); total++; if (s != "") begin bad++; $display("FAIL abort_busy_fall %s", s); end
    // abort together with the final beat
    clear_q();
    step(1, 1, 0, 0, $urandom);
    step(0, 0, 0, 1, $urandom);
    step(0, 0, 1, 1, $urandom);
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL abort_last_writes %s", s); end
    total++; if (obs_done.size() != 0 || obs_w.size() != 2) begin
      bad++; $display("FAIL abort_last_counts got %0d writes %0d dones want 2 writes 0 dones", obs_w.size(), obs_done.size());
    end
  endtask

  task automatic test_reset_mid();
    string s;
    clear_q();
    step(1, 7, 0, 0, $urandom);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom);
    reset_step(1'b1, $urandom);
    total++; if ({s_ready, ram_wr_en, busy, done} !== 4'b0) begin
      bad++; $display("FAIL rstmid_ctrl got rdy=%b wen=%b busy=%b done=%b want all 0", s_ready, ram_wr_en, busy, done);
    end
    total++; if (ram_addr !== '0 || ram_wr_data !== '0) begin
      bad++; $display("FAIL rstmid_bus got addr=%h data=%h want 0", ram_addr, ram_wr_data);
    end
    step(1, 0, 0, 0, $urandom);
    step(0, 0, 0, 1, $urandom);
    idle(3);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL rstmid_writes %s", s); end
    s = list_diff(obs_done, exp_done); total++; if (s != "") begin bad++; $display("FAIL rstmid_done %s", s); end
  endtask

  task automatic test_random();
    string s;
    int unsigned ln;
    int unsigned nd;
    clear_q();
    for (int unsigned ld = 0; ld < 30; ld++) begin
      ln = $urandom_range(0, 15);
      nd = exp_done.size();
      step(1, ln, 0, 0, $urandom);
      for (int unsigned i = 0; i < 3 * (ln + 1) + 4; i++) begin
        step(m_loading && ($urandom_range(0, 9) == 0), $urandom_range(0, 15),
             m_loading && ($urandom_range(0, 60) == 0),
             $urandom_range(0, 2) != 0, $urandom);
      end
      if (m_loading) step(0, 0, 1, 0, $urandom);
      idle(1);
`ifdef TPL_WR_CHECKSUM_EN
      if (exp_done.size() != nd) begin
        total++; if (checksum !== m_sum) begin bad++; $display("FAIL rand_checksum load %0d got %h want %h", ld, checksum, m_sum); end
      end
`endif
    end
    idle(2);
    s = wr_diff();                total++; if (s != "") begin bad++; $display("FAIL rand_writes %s", s); end
    s = list_diff(obs_done, exp_done); total++; if (s != "") begin bad++; $display("FAIL rand_done %s", s); end
    s = list_diff(obs_fall, exp_fall); total++; if (s != "") begin bad++; $display("FAIL rand_busy_fall %s", s); end
  endtask

`ifdef TPL_WR_CHECKSUM_EN
  task automatic test_checksum();
    clear_q();
    step(1, 1, 0, 0, $urandom);
    step(0, 0, 0, 1, {16'h5A5A, 16'hFFFF});
    step(0, 0, 0, 1, {16'h1234, 16'h0002});
    total++; if (done !== 1'b1 || checksum !== 16'h0001) begin
      bad++; $display("FAIL csum_at_done got done=%b sum=%h want done=1 sum=0001", done, checksum);
    end
    idle(2);
    total++; if (checksum !== 16'h0001) begin bad++; $display("FAIL csum_hold got %h want 0001", checksum); end
    step(1, 0, 0, 0, $urandom);
    total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL csum_clear got %h want 0000", checksum); end
    step(0, 0, 0, 1, $urandom);
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full_fill();
    test_abort_start();
    test_reset_mid();
`ifdef TPL_WR_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
